uop_sequencer: RTL and testbench

Microcode sequencer for the ECDSA curve point engine. Fetches 20-bit micro-operations from a registered microcode ROM (init, doubling or addition microprogram), decodes them, evaluates the per-uop execution condition, and issues each executable uop to the modular arithmetic datapath over an ena/done handshake. Execution stops at the first `OPCODE_RDY` word. It sits between the curve point top-level controller and the microprogram ROMs/operand bank.

---
 rtl/uop_ecdsa_pkg.sv | 58 +++++
 rtl/uop_cond_eval.sv | 31 +++
 rtl/uop_sequencer.sv | 142 ++++++++++++++
 tb/tb_uop_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_ecdsa_pkg.sv
// Shared definitions for the ECDSA point-engine microcode: word layout, opcodes,
// operand/exec encodings and the sequencer state type.
// Pure declarations; no logic, no latency, no flow control.
package uop_ecdsa_pkg;

    // Microcode word layout: opcode | src_a | src_b | dst | exec
    localparam int UOP_FIELD_W      = 4;
    localparam int UOP_OPCODE_LSB   = 16;
    localparam int UOP_SRC_A_LSB    = 12;
    localparam int UOP_SRC_B_LSB    = 8;
    localparam int UOP_DST_LSB      = 4;
    localparam int UOP_EXEC_LSB     = 0;
    localparam int UOP_EXEC_INV_BIT = 3;

    // Opcodes understood by the modular arithmetic datapath
    localparam logic [3:0] OPCODE_NOP = 4'h0;
    localparam logic [3:0] OPCODE_MOV = 4'h1;
    localparam logic [3:0] OPCODE_ADD = 4'h2;
    localparam logic [3:0] OPCODE_SUB = 4'h3;
    localparam logic [3:0] OPCODE_MUL = 4'h4;
    localparam logic [3:0] OPCODE_INV = 4'h5;
    localparam logic [3:0] OPCODE_RDY = 4'hF;   // end of microprogram

    // Source operand selectors in the operand bank
    localparam logic [3:0] UOP_SRC_ZERO = 4'h0;
    localparam logic [3:0] UOP_SRC_ONE  = 4'h1;
    localparam logic [3:0] UOP_SRC_RX   = 4'h2;
    localparam logic [3:0] UOP_SRC_RY   = 4'h3;
    localparam logic [3:0] UOP_SRC_RZ   = 4'h4;
    localparam logic [3:0] UOP_SRC_T0   = 4'h5;
    localparam logic [3:0] UOP_SRC_T1   = 4'h6;
    localparam logic [3:0] UOP_SRC_A    = 4'h7;
    localparam logic [3:0] UOP_SRC_B    = 4'h8;

    // Destination selectors
    localparam logic [3:0] UOP_DST_RX = 4'h2;
    localparam logic [3:0] UOP_DST_RY = 4'h3;
    localparam logic [3:0] UOP_DST_RZ = 4'h4;
    localparam logic [3:0] UOP_DST_T0 = 4'h5;
    localparam logic [3:0] UOP_DST_T1 = 4'h6;

    // Exec field: bit 3 inverts, bits 2:0 select always / flag0..flag3 / reserved
    localparam logic [3:0] UOP_EXEC_ALWAYS = 4'b0000;
    localparam logic [3:0] UOP_EXEC_FLAG0  = 4'b0001;
    localparam logic [3:0] UOP_EXEC_FLAG1  = 4'b0010;
    localparam logic [3:0] UOP_EXEC_FLAG2  = 4'b0011;
    localparam logic [3:0] UOP_EXEC_FLAG3  = 4'b0100;
    localparam logic [3:0] UOP_EXEC_INV    = 4'b1000;
    localparam logic [3:0] UOP_EXEC_NEVER  = 4'b1000;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_FETCH  = 2'd1,
        SEQ_DECODE = 2'd2,
        SEQ_WAIT   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/uop_cond_eval.sv
// Evaluates whether a decoded uop executes, from its exec field and the datapath flags.
// Purely combinational, zero latency.
// No flow control; the caller samples the result only while decoding.
module uop_cond_eval
    import uop_ecdsa_pkg::*;
(
    input  logic [3:0] i_exec,
    input  logic [3:0] i_flags,
    output logic       o_exec_go
);

    logic       w_inv;
    logic [2:0] w_sel;

    assign w_inv = i_exec[UOP_EXEC_INV_BIT];
    assign w_sel = i_exec[2:0];

    // Select the addressed flag and apply the invert bit; reserved selectors never run
    always_comb begin
        o_exec_go = 1'b0;
        case (w_sel)
            3'd0:    o_exec_go = ~w_inv;
            3'd1:    o_exec_go = i_flags[0] ^ w_inv;
            3'd2:    o_exec_go = i_flags[1] ^ w_inv;
            3'd3:    o_exec_go = i_flags[2] ^ w_inv;
            3'd4:    o_exec_go = i_flags[3] ^ w_inv;
            default: o_exec_go = 1'b0;
        endcase
    end

endmodule

// File: rtl/uop_sequencer.sv
// Microcode sequencer: fetches uops from a registered ROM, decodes, issues to the datapath.
// Per uop: 2 cycles if skipped or RDY, 3 + op_done latency if issued; issue 3 cycles after ena.
// Holds in WAIT until op_done; ena is ignored unless idle; the PC never wraps (sets err instead).
module uop_sequencer
    import uop_ecdsa_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int UOP_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              rdy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] uop_addr,
    input  logic [UOP_W-1:0]  uop_data,
    input  logic [3:0]        cond_flags,
    output logic              op_ena,
    output logic [3:0]        op_opcode,
    output logic [3:0]        op_src_a,
    output logic [3:0]        op_src_b,
    output logic [3:0]        op_dst,
    input  logic              op_done
);

    localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_rdy;
    logic              r_done;
    logic              r_err;
    logic              r_op_ena;
    logic [3:0]        r_op_opcode;
    logic [3:0]        r_op_src_a;
    logic [3:0]        r_op_src_b;
    logic [3:0]        r_op_dst;

    logic [3:0] w_opcode;
    logic [3:0] w_src_a;
    logic [3:0] w_src_b;
    logic [3:0] w_dst;
    logic [3:0] w_exec;
    logic       w_exec_go;
    logic       w_pc_last;

    assign w_opcode  = uop_data[UOP_OPCODE_LSB +: UOP_FIELD_W];
    assign w_src_a   = uop_data[UOP_SRC_A_LSB  +: UOP_FIELD_W];
    assign w_src_b   = uop_data[UOP_SRC_B_LSB  +: UOP_FIELD_W];
    assign w_dst     = uop_data[UOP_DST_LSB    +: UOP_FIELD_W];
    assign w_exec    = uop_data[UOP_EXEC_LSB   +: UOP_FIELD_W];
    assign w_pc_last = (r_pc == PC_LAST);

    uop_cond_eval u_cond_eval (
        .i_exec    (w_exec),
        .i_flags   (cond_flags),
        .o_exec_go (w_exec_go)
    );

    // Sequencer FSM; every output is a register so op_done/uop_data never reach a port combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEQ_IDLE;
            r_pc        <= '0;
            r_rdy       <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_op_ena    <= 1'b0;
            r_op_opcode <= '0;
            r_op_src_a  <= '0;
            r_op_src_b  <= '0;
            r_op_dst    <= '0;
        end else begin
            r_done   <= 1'b0;
            r_op_ena <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (ena) begin
                        r_pc    <= start_addr;
                        r_err   <= 1'b0;
                        r_rdy   <= 1'b0;
                        r_state <= SEQ_FETCH;
                    end
                end
                SEQ_FETCH: begin
                    r_state <= SEQ_DECODE;
                end
                SEQ_DECODE: begin
                    if (w_opcode == OPCODE_RDY) begin
                        r_done  <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_state <= SEQ_IDLE;
                    end else if (w_exec_go) begin
                        r_op_opcode <= w_opcode;
                        r_op_src_a  <= w_src_a;
                        r_op_src_b  <= w_src_b;
                        r_op_dst    <= w_dst;
                        r_op_ena    <= 1'b1;
                        r_state     <= SEQ_WAIT;
                    end else if (w_pc_last) begin
                        // Skipped uop at the top of the ROM: stop instead of wrapping to 0
                        r_err   <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_state <= SEQ_IDLE;
                    end else begin
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= SEQ_FETCH;
                    end
                end
                SEQ_WAIT: begin
                    if (op_done) begin
                        if (w_pc_last) begin
                            r_err   <= 1'b1;
                            r_rdy   <= 1'b1;
                            r_state <= SEQ_IDLE;
                        end else begin
                            r_pc    <= r_pc + ADDR_W'(1);
                            r_state <= SEQ_FETCH;
                        end
                    end
                end
                default: begin
                    r_rdy   <= 1'b1;
                    r_state <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign rdy       = r_rdy;
    assign done      = r_done;
    assign err       = r_err;
    assign uop_addr  = r_pc;
    assign op_ena    = r_op_ena;
    assign op_opcode = r_op_opcode;
    assign op_src_a  = r_op_src_a;
    assign op_src_b  = r_op_src_b;
    assign op_dst    = r_op_dst;

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: registered ROM model, op_done responder,
// issue scoreboard fed by the stimulus and drained by an independent monitor.
module tb_uop_sequencer;

    localparam logic [3:0] T_MOV = 4'h1, T_ADD = 4'h2, T_RDY = 4'hF;
    localparam logic [3:0] S_ZERO = 4'h0, S_ONE = 4'h1, S_RX = 4'h2, S_RY = 4'h3;
    localparam logic [3:0] D_RX = 4'h2, D_RY = 4'h3, D_RZ = 4'h4;
    localparam logic [3:0] X_ALW = 4'b0000, X_F1 = 4'b0010, X_NF1 = 4'b1010, X_RSV = 4'b0101;

    typedef struct packed {
        logic [3:0] opc;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] dst;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [5:0]  start_addr;
    logic        rdy, done, err;
    logic [5:0]  uop_addr;
    logic [19:0] uop_data = '0;
    logic [3:0]  cond_flags;
    logic        op_ena;
    logic [3:0]  op_opcode, op_src_a, op_src_b, op_dst;
    wire         op_done;

    logic        auto_pulse = 1'b0;
    logic        manual_pulse;
    logic        auto_done;
    int          done_lat;
    logic        prev_op_ena = 1'b0;
    logic        watch_zero = 1'b0;
    logic        saw_zero = 1'b0;

    logic [19:0] rom [64];
    iss_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_issue = 0;

    assign op_done = auto_pulse | manual_pulse;

    always #5 clk = ~clk;

    uop_sequencer #(.ADDR_W(6), .UOP_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start_addr (start_addr),
        .rdy        (rdy),
        .done       (done),
        .err        (err),
        .uop_addr   (uop_addr),
        .uop_data   (uop_data),
        .cond_flags (cond_flags),
        .op_ena     (op_ena),
        .op_opcode  (op_opcode),
        .op_src_a   (op_src_a),
        .op_src_b   (op_src_b),
        .op_dst     (op_dst),
        .op_done    (op_done)
    );

    // Registered microcode ROM: data follows the address by one cycle
    always @(posedge clk) uop_data <= rom[uop_addr];

    function automatic logic [19:0] uw(input logic [3:0] o, a, b, d, x);
        return {o, a, b, d, x};
    endfunction

    function automatic iss_t iss(input logic [3:0] o, a, b, d);
        iss_t t;
        t.opc = o; t.sa = a; t.sb = b; t.dst = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Datapath model: answers each issue with op_done after done_lat cycles
    always begin
        @(negedge clk);
        if (op_ena === 1'b1 && auto_done) begin
            repeat (done_lat) @(negedge clk);
            auto_pulse = 1'b1;
            @(negedge clk);
            auto_pulse = 1'b0;
        end
    end

    // Monitor: every issue must match the head of the scoreboard and be a single-cycle pulse
    always @(negedge clk) begin
        if (op_ena === 1'b1) begin
            n_issue++;
            chk("op_ena_single_cycle", 32'(prev_op_ena), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_issue: got op=%0h dst=%0h, required no issue", op_opcode, op_dst);
            end else begin
                iss_t e;
                e = exp_q.pop_front();
                chk("issue_fields", 32'({op_opcode, op_src_a, op_src_b, op_dst}), 32'(e));
            end
        end
        prev_op_ena = op_ena;
        if (watch_zero && uop_addr == 6'd0) saw_zero = 1'b1;
    end

    // Pulse ena for one cycle; returns at the middle of the first FETCH cycle (k = 1)
    task automatic kick(input logic [5:0] a);
        @(negedge clk);
        start_addr = a;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
    endtask

    // Advance until rdy is seen; k counts cycles since the accepting edge
    task automatic run_rdy(input int k0, output int k);
        k = k0;
        while (rdy !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (rdy !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: rdy=%b after %0d cycles, required 1", rdy, k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int i0;
        logic [15:0] held;

        for (int a = 0; a < 64; a++) rom[a] = uw(T_RDY, 4'h0, 4'h0, 4'h0, 4'h0);
        rom[0]  = uw(T_MOV, S_ONE,  S_ZERO, D_RX, X_ALW);
        rom[1]  = uw(T_MOV, S_ONE,  S_ZERO, D_RY, X_ALW);
        rom[2]  = uw(T_MOV, S_ZERO, S_ZERO, D_RZ, X_ALW);
        rom[8]  = uw(T_MOV, S_RX,   S_ZERO, D_RY, X_F1);
        rom[10] = uw(T_MOV, S_RY,   S_ZERO, D_RZ, X_NF1);
        rom[16] = uw(T_ADD, S_RX,   S_RY,   D_RZ, X_ALW);
        rom[20] = uw(T_MOV, S_ZERO, S_ZERO, D_RZ, X_ALW);
        rom[24] = uw(T_MOV, S_ONE,  S_ZERO, D_RX, X_RSV);
        rom[62] = uw(T_MOV, S_ONE,  S_ZERO, D_RX, X_ALW);
        rom[63] = uw(T_ADD, S_RX,   S_RY,   D_RY, X_ALW);

        rst = 1'b1; ena = 1'b0; start_addr = '0; cond_flags = 4'b0000;
        auto_done = 1'b1; done_lat = 1; manual_pulse = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_rdy", 32'(rdy), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_uop_addr", 32'(uop_addr), 32'd0);
        chk("reset_op_ena", 32'(op_ena), 32'd0);
        chk("reset_op_fields", 32'({op_opcode, op_src_a, op_src_b, op_dst}), 32'd0);
        rst = 1'b0;

        // 1: init program, op_done one cycle after op_ena (4 cycles per uop)
        exp_q.push_back(iss(T_MOV, S_ONE,  S_ZERO, D_RX));
        exp_q.push_back(iss(T_MOV, S_ONE,  S_ZERO, D_RY));
        exp_q.push_back(iss(T_MOV, S_ZERO, S_ZERO, D_RZ));
        i0 = n_issue;
        kick(6'd0);
        chk("init_fetch_rdy_low", 32'(rdy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("init_first_issue_k3", 32'(op_ena), 32'd1);
        run_rdy(3, k);
        // 14 busy cycles (3 x 4 + FETCH/DECODE of RDY); done shows in the next one
        chk("init_done_cycle", 32'(k), 32'd15);
        chk("init_done_with_rdy", 32'(done), 32'd1);
        chk("init_issue_count", 32'(n_issue - i0), 32'd3);

        // 2: conditional skip on flag1, then the inverted form
        cond_flags = 4'b0000; i0 = n_issue;
        kick(6'd8); run_rdy(1, k);
        chk("cond_f1_clear_cycles", 32'(k), 32'd5);
        chk("cond_f1_clear_issues", 32'(n_issue - i0), 32'd0);
        cond_flags = 4'b0010; i0 = n_issue;
        exp_q.push_back(iss(T_MOV, S_RX, S_ZERO, D_RY));
        kick(6'd8); run_rdy(1, k);
        chk("cond_f1_set_cycles", 32'(k), 32'd7);
        chk("cond_f1_set_issues", 32'(n_issue - i0), 32'd1);
        cond_flags = 4'b0010; i0 = n_issue;
        kick(6'd10); run_rdy(1, k);
        chk("cond_nf1_set_issues", 32'(n_issue - i0), 32'd0);
        cond_flags = 4'b0000; i0 = n_issue;
        exp_q.push_back(iss(T_MOV, S_RY, S_ZERO, D_RZ));
        kick(6'd10); run_rdy(1, k);
        chk("cond_nf1_clear_issues", 32'(n_issue - i0), 32'd1);

        // 3: slow datapath (20-cycle op_done), ena pulsed mid-run
        done_lat = 20; i0 = n_issue;
        exp_q.push_back(iss(T_ADD, S_RX, S_RY, D_RZ));
        kick(6'd16);
        @(negedge clk);
        @(negedge clk);
        chk("slow_issue_k3", 32'(op_ena), 32'd1);
        held = {op_opcode, op_src_a, op_src_b, op_dst};
        @(negedge clk);
        chk("slow_op_ena_dropped", 32'(op_ena), 32'd0);
        repeat (3) @(negedge clk);
        start_addr = 6'd0;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        chk("slow_midrun_ena_pc", 32'(uop_addr), 32'd16);
        repeat (5) @(negedge clk);
        chk("slow_fields_held", 32'({op_opcode, op_src_a, op_src_b, op_dst}), 32'(held));
        run_rdy(13, k);
        chk("slow_done_cycle", 32'(k), 32'd26);
        repeat (3) @(negedge clk);
        chk("slow_stays_idle", 32'(rdy), 32'd1);
        chk("slow_idle_pc", 32'(uop_addr), 32'd17);
        chk("slow_issue_count", 32'(n_issue - i0), 32'd1);

        // 4: run off the top of the ROM from word 62
        done_lat = 1;
        exp_q.push_back(iss(T_MOV, S_ONE, S_ZERO, D_RX));
        exp_q.push_back(iss(T_ADD, S_RX,  S_RY,   D_RY));
        watch_zero = 1'b1;
        kick(6'd62);
        run_rdy(1, k);
        watch_zero = 1'b0;
        chk("wrap_cycle", 32'(k), 32'd9);
        chk("wrap_err", 32'(err), 32'd1);
        chk("wrap_no_done", 32'(done), 32'd0);
        chk("wrap_pc_held", 32'(uop_addr), 32'd63);
        chk("wrap_never_addr0", 32'(saw_zero), 32'd0);

        // 6: reserved exec is skipped; err from the wrap is cleared by this ena
        i0 = n_issue;
        kick(6'd24);
        chk("rsv_err_cleared", 32'(err), 32'd0);
        chk("rsv_fetch_addr", 32'(uop_addr), 32'd24);
        @(negedge clk);
        @(negedge clk);
        chk("rsv_pc_advanced", 32'(uop_addr), 32'd25);
        chk("rsv_no_issue_k3", 32'(op_ena), 32'd0);
        run_rdy(3, k);
        chk("rsv_done_cycle", 32'(k), 32'd5);
        chk("rsv_issue_count", 32'(n_issue - i0), 32'd0);

        // 5: reset while in WAIT (with ena in the reset cycle), then a stray op_done
        auto_done = 1'b0;
        exp_q.push_back(iss(T_MOV, S_ZERO, S_ZERO, D_RZ));
        kick(6'd20);
        @(negedge clk);
        @(negedge clk);
        chk("rstw_issue_k3", 32'(op_ena), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;
        start_addr = 6'd5;
        @(negedge clk);
        chk("rstw_rdy", 32'(rdy), 32'd1);
        chk("rstw_op_ena", 32'(op_ena), 32'd0);
        chk("rstw_uop_addr", 32'(uop_addr), 32'd0);
        chk("rstw_op_dst", 32'(op_dst), 32'd0);
        rst = 1'b0;
        ena = 1'b0;
        manual_pulse = 1'b1;
        @(negedge clk);
        manual_pulse = 1'b0;
        @(negedge clk);
        chk("rstw_late_done_rdy", 32'(rdy), 32'd1);
        chk("rstw_late_done_pc", 32'(uop_addr), 32'd0);
        repeat (2) @(negedge clk);
        chk("rstw_still_idle", 32'(rdy), 32'd1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
